mac_stream_addrgen: RTL and testbench

Responder side of the streamer start handshake driven by the MAC control FSM. It accepts `req_start` plus an address-generation descriptor (base, transfer size, line/feature geometry) and reports `ready_start` while idle. It then produces a valid/ready stream of word addresses for one source or sink channel, ending with a `done` pulse. One instance serves each of the a/b/c/d channels, between the control FSM and the TCDM port logic.

---
 rtl/mac_stream_addrgen_pkg.sv | 36 +++
 rtl/mac_stream_addrgen.sv | 154 +++++++++++++++
 tb/tb_mac_stream_addrgen.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_stream_addrgen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mac_package
// Brief   : Shared types and constants for the MAC stream address generator.
//           Holds the FSM state encoding, the word size in bytes and the
//           latched descriptor layout.
// Revision: 1.0 - initial release
// ============================================================================
package mac_package;

  // Widths the latched descriptor is laid out for; mac_stream_addrgen
  // defaults its AW / LEN_W parameters to these values.
  localparam int unsigned MAC_ADDRGEN_AW         = 32;
  localparam int unsigned MAC_ADDRGEN_LEN_W      = 16;
  localparam int unsigned MAC_ADDRGEN_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ADDRGEN_IDLE = 2'd0,
    ADDRGEN_RUN  = 2'd1,
    ADDRGEN_DONE = 2'd2
  } addrgen_state_t;

  // Descriptor captured at start. line_len and feat_len are stored already
  // normalised (zero replaced by one), so the counter nest never sees zero.
  typedef struct packed {
    logic [MAC_ADDRGEN_AW-1:0]    base;
    logic [MAC_ADDRGEN_LEN_W-1:0] trans_size;
    logic [MAC_ADDRGEN_LEN_W-1:0] line_len;
    logic [MAC_ADDRGEN_LEN_W-1:0] line_stride;
    logic [MAC_ADDRGEN_LEN_W-1:0] feat_len;
    logic [MAC_ADDRGEN_LEN_W-1:0] feat_stride;
    logic [MAC_ADDRGEN_LEN_W-1:0] feat_roll;
  } addrgen_desc_t;

endpackage : mac_package
`default_nettype wire

// File: rtl/mac_stream_addrgen.sv
`default_nettype none
// ============================================================================
// Module  : mac_stream_addrgen
// Brief   : Per-channel address streamer. Accepts a start request with a
//           base/size/line/feature descriptor, emits a valid/ready stream of
//           word addresses and pulses done after the final handshake.
//           Optional macro MAC_ADDRGEN_FEAT_ROLL_EN adds feat_roll_i, which
//           makes the feature counter wrap after feat_roll-1 (0 = no wrap).
// Revision: 1.0 - initial release
// ============================================================================
module mac_stream_addrgen
  import mac_package::*;
#(
  parameter int unsigned AW    = MAC_ADDRGEN_AW,
  parameter int unsigned LEN_W = MAC_ADDRGEN_LEN_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             req_start_i,
  input  logic [AW-1:0]    base_addr_i,
  input  logic [LEN_W-1:0] trans_size_i,
  input  logic [LEN_W-1:0] line_length_i,
  input  logic [LEN_W-1:0] line_stride_i,
  input  logic [LEN_W-1:0] feat_length_i,
  input  logic [LEN_W-1:0] feat_stride_i,
`ifdef MAC_ADDRGEN_FEAT_ROLL_EN
  input  logic [LEN_W-1:0] feat_roll_i,
`endif
  output logic             ready_start_o,
  output logic             done_o,
  output logic             addr_valid_o,
  input  logic             addr_ready_i,
  output logic [AW-1:0]    addr_o,
  output logic             last_o
);

  addrgen_state_t   r_state;
  addrgen_desc_t    r_desc;
  addrgen_desc_t    w_desc_in;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_w;
  logic [LEN_W-1:0] r_l;
  logic [LEN_W-1:0] r_f;
  logic [AW-1:0]    r_addr;

  logic [LEN_W-1:0] w_w_nxt;
  logic [LEN_W-1:0] w_l_nxt;
  logic [LEN_W-1:0] w_f_nxt;
  logic [AW-1:0]    w_addr_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_line_end;
  logic             w_feat_end;
  logic             w_roll_end;

  // Capture the descriptor with degenerate line/feature lengths forced to one
  always_comb begin
    w_desc_in             = '0;
    w_desc_in.base        = base_addr_i;
    w_desc_in.trans_size  = trans_size_i;
    w_desc_in.line_len    = (line_length_i == '0) ? LEN_W'(1) : line_length_i;
    w_desc_in.line_stride = line_stride_i;
    w_desc_in.feat_len    = (feat_length_i == '0) ? LEN_W'(1) : feat_length_i;
    w_desc_in.feat_stride = feat_stride_i;
`ifdef MAC_ADDRGEN_FEAT_ROLL_EN
    w_desc_in.feat_roll   = feat_roll_i;
`else
    w_desc_in.feat_roll   = '0;
`endif
  end

  assign w_accept   = (r_state == ADDRGEN_RUN) && addr_ready_i;
  assign w_last     = (r_cnt == r_desc.trans_size - LEN_W'(1));
  assign w_line_end = (r_w == r_desc.line_len - LEN_W'(1));
  assign w_feat_end = (r_l == r_desc.feat_len - LEN_W'(1));
  assign w_roll_end = (r_desc.feat_roll != '0) &&
                      (r_f == r_desc.feat_roll - LEN_W'(1));

  // Word/line/feature counter nest: what the counters become after a handshake
  always_comb begin
    w_w_nxt = r_w + LEN_W'(1);
    w_l_nxt = r_l;
    w_f_nxt = r_f;
    if (w_line_end) begin
      w_w_nxt = '0;
      if (w_feat_end) begin
        w_l_nxt = '0;
        w_f_nxt = w_roll_end ? '0 : (r_f + LEN_W'(1));
      end else begin
        w_l_nxt = r_l + LEN_W'(1);
      end
    end
  end

  // Address of the next word; strides are zero-extended, arithmetic wraps at 2^AW
  assign w_addr_nxt = r_desc.base
                    + AW'(w_f_nxt) * AW'(r_desc.feat_stride)
                    + AW'(w_l_nxt) * AW'(r_desc.line_stride)
                    + AW'(w_w_nxt) * AW'(MAC_ADDRGEN_WORD_BYTES);

  // Control FSM, counters and registered address; clear behaves like reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_state <= ADDRGEN_IDLE;
      r_desc  <= '0;
      r_cnt   <= '0;
      r_w     <= '0;
      r_l     <= '0;
      r_f     <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        ADDRGEN_IDLE: begin
          if (req_start_i) begin
            r_desc  <= w_desc_in;
            r_cnt   <= '0;
            r_w     <= '0;
            r_l     <= '0;
            r_f     <= '0;
            r_addr  <= base_addr_i;
            r_state <= (trans_size_i == '0) ? ADDRGEN_DONE : ADDRGEN_RUN;
          end
        end
        ADDRGEN_RUN: begin
          if (w_accept) begin
            r_cnt  <= r_cnt + LEN_W'(1);
            r_w    <= w_w_nxt;
            r_l    <= w_l_nxt;
            r_f    <= w_f_nxt;
            r_addr <= w_addr_nxt;
            if (w_last) begin
              r_state <= ADDRGEN_DONE;
            end
          end
        end
        ADDRGEN_DONE: begin
          r_state <= ADDRGEN_IDLE;
        end
        default: begin
          r_state <= ADDRGEN_IDLE;
        end
      endcase
    end
  end

  assign ready_start_o = (r_state == ADDRGEN_IDLE);
  assign addr_valid_o  = (r_state == ADDRGEN_RUN);
  assign done_o        = (r_state == ADDRGEN_DONE);
  assign last_o        = (r_state == ADDRGEN_RUN) && w_last;
  assign addr_o        = r_addr;

endmodule : mac_stream_addrgen
`default_nettype wire

// File: tb/tb_mac_stream_addrgen.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_stream_addrgen
// Brief   : Self-checking bench for mac_stream_addrgen. Directed geometry,
//           backpressure, zero-size, abort and (with MAC_ADDRGEN_FEAT_ROLL_EN)
//           feature-roll cases, followed by randomized descriptors compared
//           against an arithmetic address model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mac_stream_addrgen;

  localparam int unsigned AW    = 32;
  localparam int unsigned LEN_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             clear_i;
  logic             req_start_i;
  logic [AW-1:0]    base_addr_i;
  logic [LEN_W-1:0] trans_size_i;
  logic [LEN_W-1:0] line_length_i;
  logic [LEN_W-1:0] line_stride_i;
  logic [LEN_W-1:0] feat_length_i;
  logic [LEN_W-1:0] feat_stride_i;
`ifdef MAC_ADDRGEN_FEAT_ROLL_EN
  logic [LEN_W-1:0] feat_roll_i;
`endif
  logic             ready_start_o;
  logic             done_o;
  logic             addr_valid_o;
  logic             addr_ready_i;
  logic [AW-1:0]    addr_o;
  logic             last_o;

  always #5 clk_i = ~clk_i;

  mac_stream_addrgen #(.AW(AW), .LEN_W(LEN_W)) u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .req_start_i   (req_start_i),
    .base_addr_i   (base_addr_i),
    .trans_size_i  (trans_size_i),
    .line_length_i (line_length_i),
    .line_stride_i (line_stride_i),
    .feat_length_i (feat_length_i),
    .feat_stride_i (feat_stride_i),
`ifdef MAC_ADDRGEN_FEAT_ROLL_EN
    .feat_roll_i   (feat_roll_i),
`endif
    .ready_start_o (ready_start_o),
    .done_o        (done_o),
    .addr_valid_o  (addr_valid_o),
    .addr_ready_i  (addr_ready_i),
    .addr_o        (addr_o),
    .last_o        (last_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Current transaction descriptor as seen by the model
  logic [31:0] d_base;
  int          d_trans, d_ll, d_ls, d_fl, d_fs, d_roll;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // k-th address of the transfer from the geometry alone
  function automatic logic [31:0] model_addr(input int k);
    int L, F, line_idx, w, l, f;
    longint unsigned a;
    L        = (d_ll == 0) ? 1 : d_ll;
    F        = (d_fl == 0) ? 1 : d_fl;
    line_idx = k / L;
    w        = k % L;
    l        = line_idx % F;
    f        = line_idx / F;
    if (d_roll != 0) f = f % d_roll;
    a = longint'(d_base) + longint'(f) * d_fs + longint'(l) * d_ls + 4 * longint'(w);
    return a[31:0];
  endfunction

  task automatic set_desc(input logic [31:0] b, input int tr, ll, ls, fl, fs, roll);
    d_base = b; d_trans = tr; d_ll = ll; d_ls = ls; d_fl = fl; d_fs = fs; d_roll = roll;
  endtask

  task automatic scramble_inputs();
    base_addr_i   = $urandom;
    trans_size_i  = LEN_W'($urandom);
    line_length_i = LEN_W'($urandom);
    line_stride_i = LEN_W'($urandom);
    feat_length_i = LEN_W'($urandom);
    feat_stride_i = LEN_W'($urandom);
`ifdef MAC_ADDRGEN_FEAT_ROLL_EN
    feat_roll_i   = LEN_W'($urandom);
`endif
  endtask

  // rmode: 0 always ready, 1 random ready, 2 ready low on cycles 1..3
  // clear_after: number of handshakes before clear_i is pulsed (-1 = never)
  task automatic run_txn(input int rmode, input int clear_after, input bit busy_starts);
    int          acc;
    bit          prev_stall, finished, rdy;
    logic [31:0] prev_addr;
    acc = 0; prev_stall = 0; finished = 0; prev_addr = '0;
    @(negedge clk_i);
    check("ready_start_idle", ready_start_o, 1);
    req_start_i   = 1'b1;
    base_addr_i   = d_base;
    trans_size_i  = LEN_W'(d_trans);
    line_length_i = LEN_W'(d_ll);
    line_stride_i = LEN_W'(d_ls);
    feat_length_i = LEN_W'(d_fl);
    feat_stride_i = LEN_W'(d_fs);
`ifdef MAC_ADDRGEN_FEAT_ROLL_EN
    feat_roll_i   = LEN_W'(d_roll);
`endif
    addr_ready_i  = 1'b0;
    @(negedge clk_i);
    req_start_i = 1'b0;
    scramble_inputs();
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (cyc != 0) @(negedge clk_i);
      if (clear_i) begin
        clear_i = 1'b0;
        check("clear_ready_start", ready_start_o, 1);
        check("clear_valid", addr_valid_o, 0);
        check("clear_done", done_o, 0);
        @(negedge clk_i);
        check("clear_no_done", done_o, 0);
        finished = 1;
        continue;
      end
      if (cyc == 0) begin
        check("first_valid", addr_valid_o, d_trans != 0);
        check("first_done", done_o, d_trans == 0);
        check("first_ready_start", ready_start_o, 0);
      end
      if (prev_stall) begin
        check("stall_valid", addr_valid_o, 1);
        check("stall_addr", addr_o, prev_addr);
      end
      if (done_o) begin
        req_start_i = 1'b0;
        check("done_count", acc, d_trans);
        check("done_valid", addr_valid_o, 0);
        @(negedge clk_i);
        check("done_pulse_width", done_o, 0);
        check("ready_after_done", ready_start_o, 1);
        finished = 1;
      end else begin
        check("valid_run", addr_valid_o, 1);
        check("last", last_o, acc == d_trans - 1);
        if (clear_after >= 0 && acc == clear_after) begin
          clear_i      = 1'b1;
          req_start_i  = 1'b0;
          addr_ready_i = 1'($urandom);
          prev_stall   = 0;
          continue;
        end
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = ($urandom_range(0, 3) != 0);
          default: rdy = !(cyc >= 1 && cyc <= 3);
        endcase
        addr_ready_i = rdy;
        if (rdy) begin
          check("addr", addr_o, model_addr(acc));
          acc++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_addr  = addr_o;
        end
        req_start_i = busy_starts ? 1'($urandom) : 1'b0;
        if (busy_starts) scramble_inputs();
      end
    end
    if (!finished) check("txn_timeout", 0, 1);
    addr_ready_i = 1'b0;
    req_start_i  = 1'b0;
    clear_i      = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; req_start_i = 1'b0; addr_ready_i = 1'b0;
    scramble_inputs();
    repeat (2) @(negedge clk_i);
    check("rst_ready_start", ready_start_o, 1);
    check("rst_valid", addr_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_last", last_o, 0);
    check("rst_addr", addr_o, 0);
    rst_ni = 1'b1;

    // Contiguous
    set_desc(32'h1000, 4, 4, 0, 1, 0, 0);
    run_txn(0, -1, 0);
    // 2D geometry
    set_desc(32'h2000, 6, 3, 32'h40, 2, 32'h100, 0);
    run_txn(0, -1, 0);
    // Backpressure
    set_desc(32'h1000, 4, 4, 0, 1, 0, 0);
    run_txn(2, -1, 0);
    // Zero-size
    set_desc(32'h3000, 0, 4, 0, 1, 0, 0);
    run_txn(0, -1, 0);
    // Degenerate geometry
    set_desc(32'h4000, 5, 0, 32'h20, 0, 32'h80, 0);
    run_txn(0, -1, 0);
    // Abort after two handshakes, then restart from base
    set_desc(32'h5000, 8, 4, 32'h40, 2, 32'h200, 0);
    run_txn(0, 2, 0);
    run_txn(0, -1, 0);
`ifdef MAC_ADDRGEN_FEAT_ROLL_EN
    set_desc(32'h0, 4, 1, 0, 1, 32'h10, 2);
    run_txn(0, -1, 0);
`endif
    // Randomized descriptors with random backpressure and ignored restarts
    for (int i = 0; i < 30; i++) begin
      int roll;
      roll = 0;
`ifdef MAC_ADDRGEN_FEAT_ROLL_EN
      roll = $urandom_range(0, 3);
`endif
      set_desc($urandom, $urandom_range(0, 24), $urandom_range(0, 5), $urandom_range(0, 65535),
               $urandom_range(0, 3), $urandom_range(0, 65535), roll);
      run_txn(1, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : -1, 1);
      if (d_base[0]) repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mac_stream_addrgen
`default_nettype wire
